hazard_sched_ctrl: RTL

Pipeline sequencing controller for the 5-stage MIPS-lite core. It sits beside the decode controller.
- Detects RAW hazards between ID and the EX/MEM stages, and generates stall and bubble controls plus forwarding selects.
- Flushes wrong-path instructions on a taken BZ/BEQ/JR.
- Sequences HALT: drains the pipeline, then freezes it.
- Keeps saturating stall/flush statistics counters.

---
 rtl/hazard_sched_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hazard_sched_ctrl.sv
// Pipeline sequencing controller: RAW hazard stall/bubble, operand forwarding,
// wrong-path flush on redirect, HALT drain/freeze, saturating statistics.
module hazard_sched_ctrl #(
   parameter int FWD_EN    = 1,
   parameter int CNT_W     = 32,
   parameter int DRAIN_CYC = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [5:0]       id_opcode,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             ex_valid,
   input  logic [4:0]       ex_rd,
   input  logic             ex_regwrite,
   input  logic             ex_is_load,
   input  logic             ex_redirect,
   input  logic             mem_valid,
   input  logic [4:0]       mem_rd,
   input  logic             mem_regwrite,
   output logic             pc_hold,
   output logic             ifid_hold,
   output logic             idex_bubble,
   output logic             ifid_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [5:0] OP_HALT = 6'h11;
   localparam int         DW      = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_HALTED
   } state_t;

   state_t          state, state_nx;
   logic [DW-1:0]   dcnt, dcnt_nx;
   logic            rs_ex, rt_ex, rs_mem, rt_mem;
   logic            stall_raw, halt_req;
   logic            stall_inc, flush_inc;

   // Per-operand RAW match against EX and MEM; r0 is never a dependency.
   always_comb begin
      rs_ex  = id_valid & id_uses_rs & ex_valid  & ex_regwrite  & (ex_rd  == id_rs) & (id_rs != 5'd0);
      rt_ex  = id_valid & id_uses_rt & ex_valid  & ex_regwrite  & (ex_rd  == id_rt) & (id_rt != 5'd0);
      rs_mem = id_valid & id_uses_rs & mem_valid & mem_regwrite & (mem_rd == id_rs) & (id_rs != 5'd0);
      rt_mem = id_valid & id_uses_rt & mem_valid & mem_regwrite & (mem_rd == id_rt) & (id_rt != 5'd0);
      if (FWD_EN != 0)
         stall_raw = (rs_ex | rt_ex) & ex_is_load;
      else
         stall_raw = rs_ex | rt_ex | rs_mem | rt_mem;
      halt_req = id_valid & (id_opcode == OP_HALT);
   end

   // Next-state and pipeline control outputs; redirect beats stall, stall defers HALT.
   always_comb begin
      state_nx    = state;
      dcnt_nx     = dcnt;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      stall_inc   = 1'b0;
      flush_inc   = 1'b0;
      if (!rst) begin
         case (state)
            S_RUN: begin
               if (ex_redirect) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  flush_inc   = 1'b1;
               end else if (stall_raw) begin
                  pc_hold     = 1'b1;
                  ifid_hold   = 1'b1;
                  idex_bubble = 1'b1;
                  stall_inc   = 1'b1;
               end else if (halt_req) begin
                  pc_hold    = 1'b1;
                  ifid_flush = 1'b1;
                  state_nx   = S_DRAIN;
                  dcnt_nx    = DW'(DRAIN_CYC - 1);
               end
            end
            S_DRAIN: begin
               pc_hold    = 1'b1;
               ifid_flush = 1'b1;
               if (dcnt == '0)
                  state_nx = S_HALTED;
               else
                  dcnt_nx = dcnt - DW'(1);
            end
            S_HALTED: begin
               pc_hold     = 1'b1;
               ifid_hold   = 1'b1;
               idex_bubble = 1'b1;
            end
            default: state_nx = S_RUN;
         endcase
      end
   end

   // Forwarding selects, EX result has priority over MEM result.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if ((FWD_EN != 0) && !rst) begin
         if (rs_ex)
            fwd_a = 2'b01;
         else if (rs_mem)
            fwd_a = 2'b10;
         if (rt_ex)
            fwd_b = 2'b01;
         else if (rt_mem)
            fwd_b = 2'b10;
      end
   end

   // State, drain counter and saturating statistics registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RUN;
         dcnt      <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_nx;
         dcnt  <= dcnt_nx;
         if (stall_inc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign halted = (state == S_HALTED);

endmodule
